// File: rtl/cmos_lane_pkg.sv
// cmos_lane_pkg: shared state encoding, staging addresses and defaults for the lane driver
package cmos_lane_pkg;
    typedef enum logic [1:0] {IDLE, SETTLE, OUT_LO, OUT_HI} state_t;
    localparam logic [1:0] ADDR_X_LO = 2'd0;
    localparam logic [1:0] ADDR_X_HI = 2'd1;
    localparam logic [1:0] ADDR_K_LO = 2'd2;
    localparam logic [1:0] ADDR_K_HI = 2'd3;
    localparam int DEF_SETTLE_CYCLES = 8;
endpackage

// File: rtl/cmos_lane_driver_if.sv
// cmos_lane_driver_if: load/start/result handshake between bus logic and the lane driver
interface cmos_lane_driver_if #(parameter int WORD = 32);
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      in_addr;
    logic [WORD-1:0] in_data;
    logic            start;
    logic            busy;
    logic            out_valid;
    logic            out_ready;
    logic [WORD-1:0] out_data;
    modport master (output in_valid, in_addr, in_data, start, out_ready,
                    input  in_ready, busy, out_valid, out_data);
    modport slave  (input  in_valid, in_addr, in_data, start, out_ready,
                    output in_ready, busy, out_valid, out_data);
endinterface

// File: rtl/cmos_lane_driver.sv
// cmos_lane_driver: stages operands, drives the lane dual-rail, waits settle time, returns s in two beats
module cmos_lane_driver
    import cmos_lane_pkg::*;
#(
    parameter int BIT_SIZE      = 64,
    parameter int WORD          = 32,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    cmos_lane_driver_if.slave   bus,
    output logic [BIT_SIZE-1:0] x_top,
    output logic [BIT_SIZE-1:0] x_bar_top,
    output logic [BIT_SIZE-1:0] k_top,
    output logic [BIT_SIZE-1:0] k_bar_top,
    input  logic [BIT_SIZE-1:0] s_top
);
    state_t              state_q, state_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [BIT_SIZE-1:0] xs_q, xs_d, ks_q, ks_d;
    logic [BIT_SIZE-1:0] x_q, x_d, xb_q, xb_d, k_q, k_d, kb_q, kb_d;
    logic [BIT_SIZE-1:0] s_q, s_d;

    assign bus.in_ready  = (state_q == IDLE) & ~bus.start;
    assign bus.busy      = state_q != IDLE;
    assign bus.out_valid = (state_q == OUT_LO) | (state_q == OUT_HI);
    assign bus.out_data  = state_q == OUT_LO ? s_q[WORD-1:0] :
                           state_q == OUT_HI ? s_q[BIT_SIZE-1:WORD] : '0;
    assign x_top     = x_q;
    assign x_bar_top = xb_q;
    assign k_top     = k_q;
    assign k_bar_top = kb_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        xs_d    = xs_q;
        ks_d    = ks_q;
        x_d     = x_q;
        xb_d    = xb_q;
        k_d     = k_q;
        kb_d    = kb_q;
        s_d     = s_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    x_d     = xs_q;
                    xb_d    = ~xs_q;
                    k_d     = ks_q;
                    kb_d    = ~ks_q;
                    cnt_d   = 8'(SETTLE_CYCLES - 1);
                    state_d = SETTLE;
                end else if (bus.in_valid) begin
                    case (bus.in_addr)
                        ADDR_X_LO: xs_d[WORD-1:0]        = bus.in_data;
                        ADDR_X_HI: xs_d[BIT_SIZE-1:WORD] = bus.in_data;
                        ADDR_K_LO: ks_d[WORD-1:0]        = bus.in_data;
                        ADDR_K_HI: ks_d[BIT_SIZE-1:WORD] = bus.in_data;
                        default: ;
                    endcase
                end
            end
            SETTLE: begin
                if (cnt_q == 8'd0) begin
                    s_d     = s_top;
                    state_d = OUT_LO;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            OUT_LO: state_d = bus.out_ready ? OUT_HI : OUT_LO;
            OUT_HI: state_d = bus.out_ready ? IDLE : OUT_HI;
            default: state_d = IDLE;
        endcase
    end

    // bar rails reset to ones so each pair stays complementary through reset
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            xs_q    <= '0;
            ks_q    <= '0;
            x_q     <= '0;
            xb_q    <= '1;
            k_q     <= '0;
            kb_q    <= '1;
            s_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            xs_q    <= xs_d;
            ks_q    <= ks_d;
            x_q     <= x_d;
            xb_q    <= xb_d;
            k_q     <= k_d;
            kb_q    <= kb_d;
            s_q     <= s_d;
        end
    end
endmodule
